conv_controller: RTL and testbench
==================================

CONV_CONTROLLER -- requirements
Module: conv_controller

Interface
REQ-001 The block SHALL have parameter KERNEL_DIM, default 3: the window side; the datapath shifts one KERNEL_DIM-pixel column per three_shift.
REQ-002 The block SHALL have parameter IMG_WIDTH, default 8: the columns per image row.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 8: the image rows; it SHALL be at least KERNEL_DIM.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a frame; it is honoured only in IDLE.
REQ-007 The block SHALL have port weight_valid, input, 1 bit: the weight source offers a coefficient.
REQ-008 The block SHALL have port weight_ready, output, 1 bit: the controller accepts a coefficient.
REQ-009 The block SHALL have port weight_write, output, 1 bit: the datapath weight-register write strobe.
REQ-010 The block SHALL have port weight_addr, output, clog2(KERNEL_DIM*KERNEL_DIM) bits: the target coefficient index.
REQ-011 The block SHALL have port pix_valid, input, 1 bit: the pixel source offers a column.
REQ-012 The block SHALL have port pix_ready, output, 1 bit: the controller accepts a column.
REQ-013 The block SHALL have port three_shift, output, 1 bit: the datapath column-shift strobe.
REQ-014 The block SHALL have port window_clear, output, 1 bit: flushes the datapath window between output rows.
REQ-015 The block SHALL have port result_valid, output, 1 bit: the datapath output holds a complete window result.
REQ-016 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: a one-cycle end-of-frame pulse.

Function
REQ-018 The FSM SHALL have five states: IDLE, LOAD_W, SHIFT, NEXT_ROW and DONE.
REQ-019 In IDLE, when start=1, the FSM SHALL move to LOAD_W on the next edge and clear all counters.
REQ-020 In LOAD_W, weight_ready SHALL be 1, and weight_write SHALL equal weight_valid & weight_ready (combinational).
REQ-021 Each weight_write SHALL increment weight_addr; the write at address KERNEL_DIM^2-1 SHALL move the FSM to SHIFT and reset weight_addr to 0.
REQ-022 In SHIFT, pix_ready SHALL be 1, and three_shift SHALL equal pix_valid & pix_ready; when pix_valid=0, the FSM SHALL stall with no strobe.
REQ-023 Each three_shift SHALL advance col_cnt, which runs 0..IMG_WIDTH-1.
REQ-024 result_valid SHALL be asserted in the cycle after each three_shift taken with col_cnt >= KERNEL_DIM-1.
REQ-025 A shift at col_cnt=IMG_WIDTH-1 SHALL wrap col_cnt to 0. If row_cnt < IMG_HEIGHT-KERNEL_DIM, the FSM SHALL move to NEXT_ROW and increment row_cnt; otherwise it SHALL move to DONE.
REQ-026 NEXT_ROW SHALL last exactly one cycle, with window_clear=1 and pix_ready=0; the FSM SHALL then return to SHIFT.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 A frame SHALL produce exactly (IMG_WIDTH-KERNEL_DIM+1)*(IMG_HEIGHT-KERNEL_DIM+1) result_valid pulses.
REQ-029 start SHALL be ignored whenever busy=1.
REQ-030 weight_ready and pix_ready SHALL never be high in the same cycle.
REQ-031 weight_valid outside LOAD_W and pix_valid outside SHIFT SHALL have no effect.
REQ-032 weight_ready, pix_ready, window_clear, result_valid, busy and done SHALL be registered.
REQ-033 Only weight_write and three_shift SHALL be combinational, each from one AND gate.

Reset
REQ-034 Assertion of reset SHALL immediately force IDLE, zero all counters, and drive every output to 0, including mid-frame.
REQ-035 After reset, no three_shift or weight_write SHALL occur until a new start is accepted.

Structure
REQ-036 Package conv_pkg SHALL hold the state enum, the KERNEL_DIM, IMG_WIDTH and IMG_HEIGHT defaults, and the derived clog2 counter widths.
REQ-037 The col/row/weight counters SHALL use one sub-module, conv_wrap_counter, parameterised by modulus, with inc, clr and wrap outputs.
REQ-038 The FSM SHALL live in conv_controller itself.

Verification
REQ-039 Reset then start, with weight_valid constant 1, SHALL give 9 consecutive weight_write pulses with addr 0..8, and SHALL enter SHIFT on the cycle after addr 8.
REQ-040 An 8x8 frame with pix_valid constant 1 SHALL give 48 three_shift, 36 result_valid (6 per row, first at the 3rd shift of each row), 5 window_clear, and 1 done.
REQ-041 pix_valid toggling 1,0,1,0 SHALL produce three_shift only on 1-cycles; the frame SHALL still end with 36 results, stalls merely lengthening it.
REQ-042 start pulsed during SHIFT SHALL have no effect; the counts SHALL match the REQ-040 scenario.
REQ-043 reset asserted at row 2, column 4, SHALL zero all outputs in the same cycle; a following start SHALL restart from LOAD_W with weight_addr=0.
REQ-044 weight_valid=1 during SHIFT, and pix_valid=1 during LOAD_W, SHALL produce no weight_write or three_shift respectively.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution controller slice: the FSM state
// encoding, default image/kernel geometry, and the counter widths that follow
// from that geometry.
// -----------------------------------------------------------------------------
package conv_pkg;

    // Controller states, in frame order
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        SHIFT    = 3'd2,
        NEXT_ROW = 3'd3,
        DONE     = 3'd4
    } conv_state_e;

    // Default geometry: 3x3 kernel sliding over an 8x8 image
    localparam int KERNEL_DIM_DEF = 3;
    localparam int IMG_WIDTH_DEF  = 8;
    localparam int IMG_HEIGHT_DEF = 8;

    // Width needed to count 0..modulus-1.
    // A modulus of 1 or 2 still gets one bit, so no counter ends up zero-width.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

    // Counter widths for the default geometry
    localparam int WEIGHT_CNT_W_DEF = cnt_width(KERNEL_DIM_DEF * KERNEL_DIM_DEF);
    localparam int COL_CNT_W_DEF    = cnt_width(IMG_WIDTH_DEF);
    localparam int ROW_CNT_W_DEF    = cnt_width(IMG_HEIGHT_DEF - KERNEL_DIM_DEF + 1);

endpackage

// File: rtl/conv_wrap_counter.sv
// -----------------------------------------------------------------------------
// conv_wrap_counter
// Modulo-MODULUS up-counter used for the weight address, the column position
// and the output-row position of the convolution controller.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-high reset, count returns to 0
//   i_inc    - advance the count by one (wrapping at MODULUS-1)
//   i_clr    - synchronous clear to 0, takes priority over i_inc
//   o_count  - current count value
//   o_wrap   - combinational: this cycle's increment rolls the count back to 0
// -----------------------------------------------------------------------------
module conv_wrap_counter
    import conv_pkg::*;
#(
    parameter int MODULUS = 8,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LAST);

    // Count register; a clear wins over an increment landing in the same cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_inc && !i_clr && w_at_last;

endmodule

// File: rtl/conv_controller.sv
// -----------------------------------------------------------------------------
// conv_controller
// Sequencing FSM for a KERNEL_DIM x KERNEL_DIM sliding-window convolution
// datapath. A frame loads KERNEL_DIM^2 weights, then shifts IMG_WIDTH pixel
// columns per output row for IMG_HEIGHT-KERNEL_DIM+1 output rows, flushing
// the window between rows.
//
// Ports:
//   clk, reset     - clock (rising edge), asynchronous active-high reset
//   start          - one-cycle frame request, only honoured in IDLE
//   weight_valid   - weight source offers a coefficient
//   weight_ready   - controller accepts a coefficient (registered)
//   weight_write   - datapath weight write strobe (weight_valid & weight_ready)
//   weight_addr    - coefficient index being written
//   pix_valid      - pixel source offers a column
//   pix_ready      - controller accepts a column (registered)
//   three_shift    - datapath column shift strobe (pix_valid & pix_ready)
//   window_clear   - flush the window between output rows (registered)
//   result_valid   - datapath output holds a full window result (registered)
//   busy           - controller is not in IDLE (registered)
//   done           - one-cycle end-of-frame pulse (registered)
// IMG_HEIGHT must be at least KERNEL_DIM.
// -----------------------------------------------------------------------------
module conv_controller
    import conv_pkg::*;
#(
    parameter int KERNEL_DIM = KERNEL_DIM_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          weight_valid,
    output logic                                          weight_ready,
    output logic                                          weight_write,
    output logic [cnt_width(KERNEL_DIM*KERNEL_DIM)-1:0]   weight_addr,
    input  logic                                          pix_valid,
    output logic                                          pix_ready,
    output logic                                          three_shift,
    output logic                                          window_clear,
    output logic                                          result_valid,
    output logic                                          busy,
    output logic                                          done
);

    localparam int NUM_WEIGHTS = KERNEL_DIM * KERNEL_DIM;
    localparam int OUT_ROWS    = IMG_HEIGHT - KERNEL_DIM + 1;
    localparam int WEIGHT_W    = cnt_width(NUM_WEIGHTS);
    localparam int COL_W       = cnt_width(IMG_WIDTH);
    localparam int ROW_W       = cnt_width(OUT_ROWS);

    conv_state_e       r_state;
    conv_state_e       w_next;

    logic              r_weight_ready;
    logic              r_pix_ready;
    logic              r_window_clear;
    logic              r_result_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_clr;
    logic              w_row_inc;
    logic              w_weight_wrap;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic [WEIGHT_W-1:0] w_weight_cnt;
    logic [COL_W-1:0]  w_col_cnt;
    logic [ROW_W-1:0]  w_row_cnt;
    logic              w_window_full;

    // The only combinational outputs: handshake strobes gated by the
    // registered ready flags, so they are forced low while reset holds
    // the ready flags at 0.
    assign weight_write = weight_valid & r_weight_ready;
    assign three_shift  = pix_valid & r_pix_ready;

    // A shift completes a window once at least KERNEL_DIM columns are in it
    assign w_window_full = (int'(w_col_cnt) >= KERNEL_DIM - 1);

    conv_wrap_counter #(
        .MODULUS (NUM_WEIGHTS),
        .WIDTH   (WEIGHT_W)
    ) u_weight_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (weight_write),
        .i_clr   (w_clr),
        .o_count (w_weight_cnt),
        .o_wrap  (w_weight_wrap)
    );

    conv_wrap_counter #(
        .MODULUS (IMG_WIDTH),
        .WIDTH   (COL_W)
    ) u_col_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (three_shift),
        .i_clr   (w_clr),
        .o_count (w_col_cnt),
        .o_wrap  (w_col_wrap)
    );

    conv_wrap_counter #(
        .MODULUS (OUT_ROWS),
        .WIDTH   (ROW_W)
    ) u_row_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_row_inc),
        .i_clr   (w_clr),
        .o_count (w_row_cnt),
        .o_wrap  (w_row_wrap)
    );

    // The row counter only advances into a following output row; the last
    // row leaves through DONE instead, so the counter never rolls over.
    always_comb begin
        assert (!w_row_wrap);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus counter clear/row-advance controls
    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_row_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = LOAD_W;
                    w_clr  = 1'b1;
                end
            end
            LOAD_W: begin
                if (w_weight_wrap) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_col_wrap) begin
                    if (int'(w_row_cnt) < IMG_HEIGHT - KERNEL_DIM) begin
                        w_next    = NEXT_ROW;
                        w_row_inc = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            NEXT_ROW: begin
                w_next = SHIFT;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state, so each one lines
    // up exactly with the state it describes. result_valid follows the
    // shift that completed a window by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_weight_ready <= 1'b0;
            r_pix_ready    <= 1'b0;
            r_window_clear <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_weight_ready <= (w_next == LOAD_W);
            r_pix_ready    <= (w_next == SHIFT);
            r_window_clear <= (w_next == NEXT_ROW);
            r_result_valid <= three_shift && w_window_full;
            r_busy         <= (w_next != IDLE);
            r_done         <= (w_next == DONE);
        end
    end

    assign weight_ready = r_weight_ready;
    assign pix_ready    = r_pix_ready;
    assign window_clear = r_window_clear;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign weight_addr  = w_weight_cnt;

endmodule

// File: tb/tb_conv_controller.sv
// -----------------------------------------------------------------------------
// tb_conv_controller
// Directed self-checking bench for conv_controller at its default 3x3 / 8x8
// geometry. Inputs change on the falling edge; everything is sampled 1ns
// later, which is where the combinational strobes show what the next rising
// edge will act on.
// -----------------------------------------------------------------------------
module tb_conv_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       weight_valid;
    logic       weight_ready;
    logic       weight_write;
    logic [3:0] weight_addr;
    logic       pix_valid;
    logic       pix_ready;
    logic       three_shift;
    logic       window_clear;
    logic       result_valid;
    logic       busy;
    logic       done;

    int testsRun    = 0;
    int testsFailed = 0;

    // Per-test activity tallies
    int nShift, nResult, nClear, nDone, nWrite, nOverlap, nBadShift, nStep;
    int rowIdx, rowShifts, doneStep;
    int firstRes [8];

    conv_controller #(
        .KERNEL_DIM (3),
        .IMG_WIDTH  (8),
        .IMG_HEIGHT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .weight_write (weight_write),
        .weight_addr  (weight_addr),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .three_shift  (three_shift),
        .window_clear (window_clear),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic clearCounts();
        nShift = 0; nResult = 0; nClear = 0; nDone = 0; nWrite = 0;
        nOverlap = 0; nBadShift = 0; nStep = 0;
        rowIdx = 0; rowShifts = 0; doneStep = -1;
        for (int i = 0; i < 8; i++) firstRes[i] = -1;
    endtask

    // Drive one cycle of inputs and tally what the DUT shows for that cycle.
    // firstRes records, per output row, how many shifts had happened in that
    // row when its first result appeared.
    task automatic step(input logic st, input logic wv, input logic pv);
        @(negedge clk);
        start        = st;
        weight_valid = wv;
        pix_valid    = pv;
        #1;
        if (result_valid) begin
            nResult++;
            if (rowIdx < 8 && firstRes[rowIdx] < 0) firstRes[rowIdx] = rowShifts;
        end
        if (three_shift) begin
            nShift++;
            rowShifts++;
            if (!pix_valid) nBadShift++;
        end
        if (window_clear) begin
            nClear++;
            rowIdx++;
            rowShifts = 0;
        end
        if (done) begin
            nDone++;
            if (doneStep < 0) doneStep = nStep;
        end
        if (weight_write) nWrite++;
        if (weight_ready && pix_ready) nOverlap++;
        nStep++;
    endtask

    // Run with weight_valid held high until done, then one more idle cycle.
    // mode 0: pix_valid constant 1; mode 1: pix_valid toggles 1,0,1,0.
    // start is pulsed at loop indices startAt and startAt+25 (if startAt >= 0).
    task automatic applyStimulus(input int mode, input int startAt, output bit timedOut);
        logic pv;
        logic st;
        timedOut = 1'b1;
        for (int k = 0; k < 400; k++) begin
            pv = (mode == 0) ? 1'b1 : ((k % 2) == 0);
            st = (startAt >= 0) && (k == startAt || k == startAt + 25);
            step(st, 1'b1, pv);
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        start        = 1'b0;
        weight_valid = 1'b1;
        pix_valid    = 1'b1;
        @(negedge clk);
        #1;
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++;
        if (weight_ready !== 1'b0 || pix_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready: got weight_ready=%b pix_ready=%b expected 0/0", weight_ready, pix_ready);
        end
        testsRun++;
        if (weight_write !== 1'b0 || three_shift !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got weight_write=%b three_shift=%b expected 0/0", weight_write, three_shift);
        end
        testsRun++;
        if (window_clear !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: got clear=%b result=%b done=%b expected 0/0/0", window_clear, result_valid, done);
        end
        testsRun++;
        if (weight_addr !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %0d expected 0", weight_addr); end
        @(negedge clk);
        reset        = 1'b0;
        weight_valid = 1'b0;
        pix_valid    = 1'b0;
    endtask

    // Weight load with pix_valid held high throughout: nine writes 0..8,
    // no shifts during the load, SHIFT the cycle after address 8.
    task automatic test_load_weights();
        bit to;
        int badShift;
        clearCounts();
        badShift = 0;
        step(1'b1, 1'b1, 1'b1);
        testsRun++;
        if (weight_write !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_no_write: got %b expected 0", weight_write); end
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b1);
            testsRun++;
            if (weight_write !== 1'b1 || weight_addr !== 4'(i)) begin
                testsFailed++;
                $display("[TB] FAIL load_write_%0d: got write=%b addr=%0d expected 1/%0d", i, weight_write, weight_addr, i);
            end
            if (three_shift !== 1'b0) badShift++;
        end
        testsRun++;
        if (badShift !== 0) begin testsFailed++; $display("[TB] FAIL load_no_shift: got %0d shifts expected 0", badShift); end
        step(1'b0, 1'b1, 1'b1);
        testsRun++;
        if (pix_ready !== 1'b1 || weight_ready !== 1'b0 || weight_write !== 1'b0 || weight_addr !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL enter_shift: got pix_ready=%b weight_ready=%b write=%b addr=%0d expected 1/0/0/0",
                     pix_ready, weight_ready, weight_write, weight_addr);
        end
        applyStimulus(0, -1, to);
        testsRun++;
        if (to) begin testsFailed++; $display("[TB] FAIL load_frame_timeout: done not seen within budget"); end
        testsRun++;
        if (nWrite !== 9) begin testsFailed++; $display("[TB] FAIL shift_no_write: got %0d writes expected 9", nWrite); end
    endtask

    task automatic test_full_frame();
        bit to;
        clearCounts();
        step(1'b1, 1'b1, 1'b1);
        applyStimulus(0, -1, to);
        testsRun++;
        if (to) begin testsFailed++; $display("[TB] FAIL frame_timeout: done not seen within budget"); end
        testsRun++;
        if (nShift !== 48) begin testsFailed++; $display("[TB] FAIL frame_shifts: got %0d expected 48", nShift); end
        testsRun++;
        if (nResult !== 36) begin testsFailed++; $display("[TB] FAIL frame_results: got %0d expected 36", nResult); end
        testsRun++;
        if (nClear !== 5) begin testsFailed++; $display("[TB] FAIL frame_clears: got %0d expected 5", nClear); end
        testsRun++;
        if (nDone !== 1) begin testsFailed++; $display("[TB] FAIL frame_done: got %0d expected 1", nDone); end
        testsRun++;
        if (doneStep !== 63) begin testsFailed++; $display("[TB] FAIL frame_latency: got done at cycle %0d expected 63", doneStep); end
        testsRun++;
        if (nOverlap !== 0) begin testsFailed++; $display("[TB] FAIL ready_overlap: got %0d cycles expected 0", nOverlap); end
        for (int r = 0; r < 6; r++) begin
            testsRun++;
            if (firstRes[r] !== 3) begin
                testsFailed++;
                $display("[TB] FAIL first_result_row%0d: got after shift %0d expected 3", r, firstRes[r]);
            end
        end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_after_done: got busy=%b expected 0", busy); end
    endtask

    task automatic test_stall();
        bit to;
        clearCounts();
        step(1'b1, 1'b1, 1'b1);
        applyStimulus(1, -1, to);
        testsRun++;
        if (to) begin testsFailed++; $display("[TB] FAIL stall_timeout: done not seen within budget"); end
        testsRun++;
        if (nShift !== 48 || nResult !== 36) begin
            testsFailed++;
            $display("[TB] FAIL stall_counts: got shifts=%0d results=%0d expected 48/36", nShift, nResult);
        end
        testsRun++;
        if (nBadShift !== 0) begin testsFailed++; $display("[TB] FAIL stall_strobe: got %0d shifts without pix_valid expected 0", nBadShift); end
        testsRun++;
        if (doneStep <= 63) begin testsFailed++; $display("[TB] FAIL stall_longer: got done at cycle %0d expected later than 63", doneStep); end
    endtask

    task automatic test_start_ignored();
        bit to;
        clearCounts();
        step(1'b1, 1'b1, 1'b1);
        applyStimulus(0, 15, to);
        testsRun++;
        if (to) begin testsFailed++; $display("[TB] FAIL busy_start_timeout: done not seen within budget"); end
        testsRun++;
        if (nShift !== 48 || nResult !== 36 || nClear !== 5 || nDone !== 1 || nWrite !== 9) begin
            testsFailed++;
            $display("[TB] FAIL busy_start_counts: got shift=%0d result=%0d clear=%0d done=%0d write=%0d expected 48/36/5/1/9",
                     nShift, nResult, nClear, nDone, nWrite);
        end
        testsRun++;
        if (doneStep !== 63) begin testsFailed++; $display("[TB] FAIL busy_start_latency: got done at cycle %0d expected 63", doneStep); end
    endtask

    task automatic test_mid_reset();
        bit to;
        int guard;
        clearCounts();
        step(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (!(rowIdx == 2 && rowShifts == 4) && guard < 200) begin
            step(1'b0, 1'b1, 1'b1);
            guard++;
        end
        testsRun++;
        if (guard >= 200) begin testsFailed++; $display("[TB] FAIL midreset_reach: row 2 column 4 not reached within budget"); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if ({busy, pix_ready, weight_ready, three_shift, weight_write, result_valid, window_clear, done} !== 8'd0
            || weight_addr !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got busy=%b pr=%b wr=%b shift=%b write=%b res=%b clr=%b done=%b addr=%0d expected all 0",
                     busy, pix_ready, weight_ready, three_shift, weight_write, result_valid, window_clear, done, weight_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        clearCounts();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        testsRun++;
        if (nShift !== 0 || nWrite !== 0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_quiet: got shifts=%0d writes=%0d busy=%b expected 0/0/0", nShift, nWrite, busy);
        end
        clearCounts();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        testsRun++;
        if (weight_ready !== 1'b1 || weight_write !== 1'b1 || weight_addr !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL restart_load: got ready=%b write=%b addr=%0d expected 1/1/0", weight_ready, weight_write, weight_addr);
        end
        applyStimulus(0, -1, to);
        testsRun++;
        if (to || nResult !== 36 || nDone !== 1) begin
            testsFailed++;
            $display("[TB] FAIL restart_frame: got timeout=%b results=%0d done=%0d expected 0/36/1", to, nResult, nDone);
        end
    endtask

    initial begin
        test_reset();
        test_load_weights();
        test_full_frame();
        test_stall();
        test_start_ignored();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
